// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder: state encoding, bus widths,
// address-to-word-index slicing and the out-of-range test.
package mem_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // depth is a power of two, so masking the word address equals addr[$clog2(depth)+1:2]
  function automatic logic [ADDR_W-1:0] addr_to_index(input logic [ADDR_W-1:0] addr,
                                                      input int unsigned depth);
    return (addr >> 2) & ADDR_W'(depth - 1);
  endfunction

  function automatic logic addr_oob(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr >> 2) >= ADDR_W'(depth);
  endfunction
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM, one-cycle read; a write returns the new data on rdata.
// Contents are not reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] index,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);
  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
      rdata      <= wdata;
    end else begin
      rdata <= mem[index];
    end
  end
endmodule

// File: rtl/mem_responder.sv
// One-at-a-time memory responder: resp_valid pulses in the LATENCY-th cycle after accept; busy requests are dropped.
// MEM_BOUNDS_CHECK_EN: addresses >= DEPTH*4 fault with resp_err instead of aliasing.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              go_resp;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic              act_we;
  logic [ADDR_W-1:0] act_addr;
  logic [WORD_W-1:0] act_wdata;
  logic              cap_oob, act_oob;
  logic              mem_we;
  logic [WORD_W-1:0] mem_rdata;

  // With LATENCY==1 the RAM access shares the accept edge, so it must see the live bus.
  assign act_we    = (state == IDLE) ? req_we    : cap_we;
  assign act_addr  = (state == IDLE) ? req_addr  : cap_addr;
  assign act_wdata = (state == IDLE) ? req_wdata : cap_wdata;

`ifdef MEM_BOUNDS_CHECK_EN
  assign cap_oob = addr_oob(cap_addr, DEPTH);
  assign act_oob = addr_oob(act_addr, DEPTH);
`else
  assign cap_oob = 1'b0;
  assign act_oob = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && req_valid) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    go_resp    = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nx = RESP;
            go_resp  = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        // The final decrement coincides with the edge into RESP, so the counter never wraps.
        if (cnt <= CNT_W'(1)) begin
          state_nx = RESP;
          go_resp  = 1'b1;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_we = go_resp & act_we & ~act_oob & ~rst;

  mem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .index (IDX_W'(addr_to_index(act_addr, DEPTH))),
    .wdata (act_wdata),
    .rdata (mem_rdata)
  );

  assign resp_err   = resp_valid & cap_oob;
  assign resp_rdata = (resp_valid && !cap_oob) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: instance 0 uses LATENCY=3, instance 1 uses LATENCY=1; both DEPTH=1024.
module tb_mem_responder;
  logic        clk;
  logic        rst;
  logic        req_valid  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int n_cmp = 0;
  int n_bad = 0;

  mem_responder #(.DEPTH(1024), .LATENCY(3)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_ready(req_ready[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  mem_responder #(.DEPTH(1024), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_ready(req_ready[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request; the bus is scrambled after accept (optionally with a competing
  // request held valid) and the response cycle index counted from the accept edge.
  task automatic txn(input int s, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic intrude, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = addr; req_wdata[s] = wd;
    @(posedge clk); #1;
    req_valid[s] = intrude; req_we[s] = 1'b1; req_addr[s] = 32'h30; req_wdata[s] = 32'h1111_1111;
    if (intrude) chk("busy_ready", {31'b0, req_ready[s]}, 32'd0);
    rd = '0; er = 1'b0; lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (resp_valid[s]) begin
        lat = i; rd = resp_rdata[s]; er = resp_err[s];
        break;
      end
      @(posedge clk); #1;
    end
    req_valid[s] = 1'b0;
    @(posedge clk); #1;
    chk("pulse_end", {31'b0, resp_valid[s]}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0; req_wdata[s] = '0;
    end
    #1;
    chk("rst_ready", {31'b0, req_ready[0]}, 32'd1);
    chk("rst_valid", {31'b0, resp_valid[0]}, 32'd0);
    chk("rst_rdata", resp_rdata[0], 32'd0);
    chk("rst_err", {31'b0, resp_err[0]}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("idle_ready", {31'b0, req_ready[0]}, 32'd1);
      chk("idle_valid", {31'b0, resp_valid[0]}, 32'd0);
    end

    // Write then read back with LATENCY=3
    txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, rd, er, lat);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_echo", rd, 32'hDEAD_BEEF);
    chk("wr_err", {31'b0, er}, 32'd0);
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, rd, er, lat);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", rd, 32'hDEAD_BEEF);

    // Busy rejection and captured-field independence
    txn(0, 1'b1, 32'h30, 32'h3030_3030, 1'b0, rd, er, lat);
    txn(0, 1'b1, 32'h40, 32'h4444_4444, 1'b1, rd, er, lat);
    chk("busy_lat", 32'(lat), 32'd3);
    chk("busy_echo", rd, 32'h4444_4444);
    txn(0, 1'b0, 32'h40, 32'h0, 1'b0, rd, er, lat);
    chk("busy_cap_addr", rd, 32'h4444_4444);
    txn(0, 1'b0, 32'h30, 32'h0, 1'b0, rd, er, lat);
    chk("busy_ignored", rd, 32'h3030_3030);
    txn(0, 1'b1, 32'h30, 32'h1111_1111, 1'b0, rd, er, lat);
    chk("represent_lat", 32'(lat), 32'd3);
    txn(0, 1'b0, 32'h30, 32'h0, 1'b0, rd, er, lat);
    chk("represent_data", rd, 32'h1111_1111);

    // Reset during WAIT discards the pending write
    txn(0, 1'b1, 32'h20, 32'h0000_0000, 1'b0, rd, er, lat);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("wait_ready", {31'b0, req_ready[0]}, 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'b0, req_ready[0]}, 32'd1);
    chk("arst_valid", {31'b0, resp_valid[0]}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("arst_no_resp", {31'b0, resp_valid[0]}, 32'd0);
    end
    chk("arst_idle", {31'b0, req_ready[0]}, 32'd1);
    txn(0, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat);
    chk("arst_no_write", rd, 32'h0000_0000);

    // Address beyond DEPTH*4
    txn(0, 1'b1, 32'h4, 32'h0404_0404, 1'b0, rd, er, lat);
    txn(0, 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 1'b0, rd, er, lat);
    chk("oob_lat", 32'(lat), 32'd3);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("oob_err", {31'b0, er}, 32'd1);
    chk("oob_rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h4, 32'h0, 1'b0, rd, er, lat);
    chk("oob_word1", rd, 32'h0404_0404);
`else
    chk("alias_err", {31'b0, er}, 32'd0);
    chk("alias_echo", rd, 32'hCAFE_F00D);
    txn(0, 1'b0, 32'h4, 32'h0, 1'b0, rd, er, lat);
    chk("alias_word1", rd, 32'hCAFE_F00D);
`endif

    // LATENCY=1: back-to-back writes, one accept every two cycles
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h4; req_wdata[1] = 32'hAAAA_0004;
    @(posedge clk); #1;
    chk("l1_resp0", {31'b0, resp_valid[1]}, 32'd1);
    chk("l1_data0", resp_rdata[1], 32'hAAAA_0004);
    chk("l1_busy0", {31'b0, req_ready[1]}, 32'd0);
    req_addr[1] = 32'h8; req_wdata[1] = 32'hBBBB_0008;
    @(posedge clk); #1;
    chk("l1_gap_valid", {31'b0, resp_valid[1]}, 32'd0);
    chk("l1_gap_ready", {31'b0, req_ready[1]}, 32'd1);
    @(posedge clk); #1;
    chk("l1_resp1", {31'b0, resp_valid[1]}, 32'd1);
    chk("l1_data1", resp_rdata[1], 32'hBBBB_0008);
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("l1_end", {31'b0, resp_valid[1]}, 32'd0);
    txn(1, 1'b0, 32'h4, 32'h0, 1'b0, rd, er, lat);
    chk("l1_rd_lat", 32'(lat), 32'd1);
    chk("l1_rd4", rd, 32'hAAAA_0004);
    txn(1, 1'b0, 32'h8, 32'h0, 1'b0, rd, er, lat);
    chk("l1_rd8", rd, 32'hBBBB_0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's instruction and data bus.
- Accepts one read or write request at a time and stores data in an internal word array.
- Returns a single-cycle response after a fixed, parameterised latency.
- Sits between cpu_logic and the backing store, so the CPU can be verified against realistic wait states.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two, >= 2.
- LATENCY, 3, cycles from request accept edge to resp_valid; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  CPU presents a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address; bits [1:0] ignored (word-aligned).
- req_wdata  input  32  write data.
- req_ready  output  1  responder can accept a request this cycle.
- resp_valid  output  1  one-cycle pulse; response is present.
- resp_rdata  output  32  read data, or echoed write data on writes.
- resp_err  output  1  address fault, qualified by resp_valid.

Behaviour:
- Reset is asynchronous and active-high; clk is the single clock.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Array contents are not reset.
- Word index = req_addr[$clog2(DEPTH)+1:2].
- States:
  - IDLE: req_ready=1. When req_valid=1 at a rising edge, capture we/addr/wdata, load counter=LATENCY-1, then go to WAIT. If LATENCY==1, go directly to RESP.
  - WAIT: req_ready=0. Decrement the counter each cycle; when the counter reaches 0, go to RESP on the next edge.
  - RESP: resp_valid=1 for exactly one cycle and req_ready=0. The next state is always IDLE.
- Timing: resp_valid rises exactly LATENCY cycles after the accept edge. Sustained throughput is one request per LATENCY+1 cycles.
- Write commit: the array write happens on the edge that enters RESP, not at accept. resp_rdata = captured wdata.
- Read: resp_rdata = array[index], sampled on the edge that enters RESP. A read following a write to the same address returns the new data.
- The request is not held by the CPU after accept. Captured fields are used; bus changes during WAIT have no effect.
- req_valid asserted while req_ready=0 is ignored; no queuing. The CPU must re-present the request.
- No backpressure on the response: resp_valid is a pulse and is never stretched.
- Reset mid-operation aborts immediately: a pending write is discarded, no resp_valid pulse occurs, and the block is in IDLE on the first edge after rst falls.
- The latency counter width is $clog2(LATENCY+1) and must never underflow.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined: a captured address >= DEPTH*4 yields resp_err=1 with resp_valid, resp_rdata=0, and the write is suppressed. Latency is unchanged.
- Undefined: upper address bits are truncated, so addresses alias modulo DEPTH*4. resp_err is tied to 0.

Decomposition:
- Shared package/header mem_pkg holds:
  - state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - WORD_W=32 and ADDR_W=32.
  - the shared address-to-index slicing function.
- Sub-module mem_array: single-port synchronous RAM with clk, we, index, wdata, rdata and read-during-write returning new data. The FSM and counter live in mem_responder.

Test Plan:
- Reset and idle: assert rst mid-cycle -> outputs take their reset values asynchronously. After release with req_valid=0 for 10 cycles -> req_ready=1 and resp_valid stays 0.
- Write then read, LATENCY=3: write 0xDEADBEEF to 0x0000_0010 -> resp_valid exactly 3 cycles after accept, resp_rdata=0xDEADBEEF. Then read 0x10 -> 0xDEADBEEF with the same latency.
- Busy rejection: present a second request during WAIT -> req_ready=0 and the request is ignored. Re-presenting it after resp_valid is accepted; the earlier captured address is unaffected by bus changes.
- LATENCY=1 build: back-to-back writes to 0x4 and 0x8 -> each responds on the cycle after accept, with one accept every 2 cycles.
- Reset mid-write: write 0x12345678 to 0x20, assert rst during WAIT -> no resp_valid. A following read of 0x20 returns the prior value 0x00000000, which is pre-written by the bench.
- Bounds, DEPTH=1024: write to 0x0000_1004. With MEM_BOUNDS_CHECK_EN -> resp_err=1 and word 1 unchanged. Without it -> word 1 = written data and resp_err=0.
